fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 16 +
 rtl/fifo_reader_skid.sv | 74 +++++++
 rtl/fifo_reader.sv | 71 +++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO reader: buffer occupancy encoding and beat counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_reader_pkg;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } occ_e;

    // Width of the per-packet beat counter
    localparam int CNT_W = 8;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer between a FWFT FIFO and a registered valid/ready stream.
// Latency: a pushed word is presented on head_o/vld_o one cycle after the push edge.
// Backpressure: holds head while accept_i=0; push is ignored when full (caller gates it).
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             accept_i,
    output logic [WIDTH-1:0] head_o,
    output logic             vld_o,
    output occ_e             state_o
);

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    // Next occupancy and entry contents; head is always the oldest word
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ZERO: begin
                if (push_i) begin
                    head_d  = push_dat_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push_i && accept_i) begin
                    head_d = push_dat_i;
                end else if (push_i) begin
                    tail_d  = push_dat_i;
                    state_d = TWO;
                end else if (accept_i) begin
                    state_d = ZERO;
                end
            end
            TWO: begin
                if (accept_i) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    // Buffer registers; reset discards anything held
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ZERO;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign head_o  = head_q;
    assign vld_o   = (state_q != ZERO);
    assign state_o = state_q;

endmodule

// File: rtl/fifo_reader.sv
// Pops a FWFT FIFO into a registered valid/ready stream; optional packet framing (FIFO_RD_PKT_EN).
// Latency: one cycle from pop edge to dat_o/vld_o when the buffer is empty.
// Backpressure: pops stop once two words are buffered; buffered words drain even with en_i low.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PKT_LEN = 4
) (
    input  logic             rclk,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             empty,
    input  logic [WIDTH-1:0] dat_i,
    output logic             ren,
    output logic [WIDTH-1:0] dat_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic             last_o
);

    occ_e occ;
    logic accept;

    // Reset is folded in so the FIFO never advances while we are discarding state
    assign ren    = en_i & ~empty & ~rst_i & (occ != TWO);
    assign accept = vld_o & rdy_i;

    fifo_reader_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i      (rclk),
        .rst_i      (rst_i),
        .push_i     (ren),
        .push_dat_i (dat_i),
        .accept_i   (accept),
        .head_o     (dat_o),
        .vld_o      (vld_o),
        .state_o    (occ)
    );

`ifdef FIFO_RD_PKT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Beat position within the packet, advanced only on accepted beats
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Beat counter register
    always_ff @(posedge rclk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = vld_o & (cnt_q == CNT_MAX);
`else
    logic pkt_len_unused;
    assign pkt_len_unused = (PKT_LEN > 0);
    assign last_o         = 1'b0;
`endif

endmodule
